// File: rtl/feistel_pkg.sv
// feistel_pkg: shared state encoding, default sizing and round-index width helper
package feistel_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int DEF_W = 64;
   localparam int DEF_ROUNDS = 16;
   function automatic int rcw(input int rounds);
      return (rounds > 1) ? $clog2(rounds) : 1;
   endfunction
endpackage

// File: rtl/feistel_half_engine_round_counter.sv
// round_counter: saturating round index, cleared on load, flags the final round
module round_counter
   import feistel_pkg::*;
#(
   parameter int ROUNDS = DEF_ROUNDS,
   localparam int RCW = rcw(ROUNDS)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           inc,
   output logic [RCW-1:0] cnt,
   output logic           last
);
   localparam logic [RCW-1:0] LAST = RCW'(ROUNDS - 1);
   assign last = cnt == LAST;
   always_ff @(posedge clk) begin
      if (reset || load) cnt <= '0;
      else if (inc && !last) cnt <= cnt + RCW'(1);
   end
endmodule

// File: rtl/feistel_half_engine.sv
// feistel_half_engine: iterative Feistel core pacing one round per clk_en pulse,
// with the F function supplied externally through f_in/f_out.
module feistel_half_engine
   import feistel_pkg::*;
#(
   parameter int W = DEF_W,
   parameter int ROUNDS = DEF_ROUNDS,
   localparam int RCW = rcw(ROUNDS)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           clk_en,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   begin_l,
   input  logic [W-1:0]   begin_r,
   input  logic           decrypt,
   output logic [W-1:0]   f_in,
   input  logic [W-1:0]   f_out,
   input  logic           f_valid,
   output logic [RCW-1:0] round_idx,
   output logic           busy,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_l,
   output logic [W-1:0]   out_r
);
   localparam logic [RCW-1:0] LAST = RCW'(ROUNDS - 1);
   state_t state, state_n;
   logic [W-1:0] l_reg, r_reg;
   logic [RCW-1:0] rnd;
   logic dec, last, load, retire;
   assign load = state == IDLE && in_valid;
   assign retire = state == RUN && clk_en && f_valid;
   round_counter #(.ROUNDS(ROUNDS)) u_cnt (
      .clk(clk), .reset(reset), .load(load), .inc(retire), .cnt(rnd), .last(last)
   );
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      in_ready = state == IDLE;
      busy = state == RUN;
      out_valid = state == DONE;
      if (load) state_n = RUN;
      if (retire && last) state_n = DONE;
      if (out_valid && out_ready) state_n = IDLE;
   end
   // final round skips the swap so decryption is the same datapath with reversed subkeys
   always_ff @(posedge clk) begin
      if (reset) begin
         l_reg <= '0;
         r_reg <= '0;
         dec <= 1'b0;
      end else if (load) begin
         l_reg <= begin_l;
         r_reg <= begin_r;
         dec <= decrypt;
      end else if (retire) begin
         if (last) l_reg <= l_reg ^ f_out;
         else begin
            l_reg <= r_reg;
            r_reg <= l_reg ^ f_out;
         end
      end
   end
   assign f_in = r_reg;
   assign round_idx = dec ? LAST - rnd : rnd;
   assign out_l = out_valid ? l_reg : '0;
   assign out_r = out_valid ? r_reg : '0;
endmodule
